// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, imem req/ready fetch, jump/branch redirect and a one-entry skid buffer.
// Optional exception redirect to EXC_VECTOR (with epc capture) is built when IF_EXC_VECTOR_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_FETCH   | requesting pc_r, transfers feed if_id or the skid
// S_DISCARD | redirected with a request in flight; drop its response
// S_HOLD    | skid holds a fetched word while if_id is stalled
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
`ifdef IF_EXC_VECTOR_EN
    input  logic        exc_req,
    output logic [31:0] epc,
`endif
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_4,
    output logic [31:0] instr,
    output logic        if_valid,
    output logic        if_flush
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DISCARD = 2'd1,
        S_HOLD    = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_r_q, pc_r_d;
    logic [31:0] stale_addr_q, stale_addr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_4_q, pc_4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        flush_q, flush_d;
`ifdef IF_EXC_VECTOR_EN
    logic [31:0] epc_q, epc_d;
`endif

    logic        exc_hit;
    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        xfer;
    logic [31:0] pc_r_inc;

`ifdef IF_EXC_VECTOR_EN
    assign exc_hit = exc_req;
`else
    assign exc_hit = 1'b0;
`endif

    assign redirect   = exc_hit | jump | branch_taken;
    assign target_raw = exc_hit ? EXC_VECTOR : (jump ? jump_target : branch_target);
    assign target     = target_raw & ~32'h3;
    assign pc_r_inc   = pc_r_q + 32'd4;

    // reset gates the request so nothing is issued while the stage is held in reset
    assign imem_req  = ~reset & (state_q != S_HOLD);
    assign imem_addr = (state_q == S_DISCARD) ? stale_addr_q : pc_r_q;
    assign xfer      = imem_req & imem_ready;

    always_comb begin
        state_d      = state_q;
        pc_r_d       = pc_r_q;
        stale_addr_d = stale_addr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        pc_d         = pc_q;
        pc_4_d       = pc_4_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        flush_d      = 1'b0;
`ifdef IF_EXC_VECTOR_EN
        epc_d        = epc_q;
`endif

        if (redirect) begin
            pc_r_d       = target;
            pc_d         = 32'h0;
            pc_4_d       = 32'h0;
            instr_d      = 32'h0;
            valid_d      = 1'b0;
            flush_d      = 1'b1;
            skid_pc_d    = 32'h0;
            skid_instr_d = 32'h0;
`ifdef IF_EXC_VECTOR_EN
            if (exc_hit) begin
                epc_d = pc_r_q;
            end
`endif
            case (state_q)
                S_FETCH: begin
                    // a word landing this cycle is simply dropped; only an open request needs draining
                    if (!xfer) begin
                        state_d      = S_DISCARD;
                        stale_addr_d = pc_r_q;
                    end
                end
                S_DISCARD: begin
                    if (xfer) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (xfer) begin
                        pc_r_d = pc_r_inc;
                        if (pc_write) begin
                            pc_d    = pc_r_q;
                            pc_4_d  = pc_r_inc;
                            instr_d = imem_rdata;
                            valid_d = 1'b1;
                        end else begin
                            skid_pc_d    = pc_r_q;
                            skid_instr_d = imem_rdata;
                            state_d      = S_HOLD;
                        end
                    end else if (pc_write) begin
                        valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (pc_write) begin
                        pc_d    = skid_pc_q;
                        pc_4_d  = skid_pc_q + 32'd4;
                        instr_d = skid_instr_q;
                        valid_d = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (xfer) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_r_q       <= RESET_PC;
            stale_addr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            skid_instr_q <= 32'h0;
            pc_q         <= 32'h0;
            pc_4_q       <= 32'h0;
            instr_q      <= 32'h0;
            valid_q      <= 1'b0;
            flush_q      <= 1'b0;
`ifdef IF_EXC_VECTOR_EN
            epc_q        <= 32'h0;
`endif
        end else begin
            state_q      <= state_d;
            pc_r_q       <= pc_r_d;
            stale_addr_q <= stale_addr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            pc_q         <= pc_d;
            pc_4_q       <= pc_4_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
            flush_q      <= flush_d;
`ifdef IF_EXC_VECTOR_EN
            epc_q        <= epc_d;
`endif
        end
    end

    assign pc       = pc_q;
    assign pc_4     = pc_4_q;
    assign instr    = instr_q;
    assign if_valid = valid_q;
    assign if_flush = flush_q;
`ifdef IF_EXC_VECTOR_EN
    assign epc      = epc_q;
`endif

endmodule
